ddr3_cmd_decoder: RTL and testbench

- Memory-side endpoint of the DDR3 command/address bus, on the DDR3 pins after PCB delay.
- Samples cke/cs_n/ras_n/cas_n/we_n/ba/addr each clock, decodes JEDEC commands and tracks per-bank state and timing.
- Emits decoded-command pulses, captured MR0 fields and protocol-error flags.
- Used by the UVM monitor/scoreboard as the reference view of what the controller issued.

---
 rtl/ddr3_cmd_pkg.sv | 40 ++++
 rtl/ddr3_bank_fsm.sv | 98 +++++++++
 rtl/ddr3_cmd_decoder.sv | 193 +++++++++++++++++++
 tb/tb_ddr3_cmd_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_cmd_pkg.sv
// Shared command, error and bank-state encodings for the DDR3 command decoder.
package ddr3_cmd_pkg;

    localparam int unsigned CMD_W = 4;
    localparam int unsigned ERR_W = 4;
    localparam int unsigned COL_W = 10;

    localparam logic [1:0] MR0_BL_OTF = 2'b01;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 4'd0,
        CMD_ACT  = 4'd1,
        CMD_RD   = 4'd2,
        CMD_WR   = 4'd3,
        CMD_PRE  = 4'd4,
        CMD_PREA = 4'd5,
        CMD_REF  = 4'd6,
        CMD_MRS  = 4'd7,
        CMD_ZQ   = 4'd8
    } cmd_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE     = 4'd0,
        ERR_TRFC     = 4'd1,
        ERR_ACT_OPEN = 4'd2,
        ERR_TRP      = 4'd3,
        ERR_TRCD     = 4'd4,
        ERR_NOT_OPEN = 4'd5,
        ERR_TRAS     = 4'd6,
        ERR_REF_OPEN = 4'd7
    } err_e;

    typedef enum logic [1:0] {
        BANK_IDLE        = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_ACTIVE      = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/ddr3_bank_fsm.sv
// Per-bank state tracker: state, open row and the tRCD/tRAS/tRP countdowns.
// Counters are loaded with N-1 so that a command N clocks later sees zero.
module ddr3_bank_fsm
    import ddr3_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned TRCD       = 6,
    parameter int unsigned TRP        = 6,
    parameter int unsigned TRAS       = 15,
    parameter int unsigned TAP        = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  act,
    input  logic                  rdwr,
    input  logic                  ap,
    input  logic                  pre,
    input  logic [ADDR_WIDTH-1:0] row_in,
    output logic [1:0]            eff_state_c,
    output logic                  ras_ok_c,
    output logic [ADDR_WIDTH-1:0] open_row
);

    localparam int unsigned RCD_W = $clog2(TRCD + 1);
    localparam int unsigned RAS_W = $clog2(TRAS + 1);
    localparam int unsigned RP_W  = $clog2(TAP + TRP + 1);

    bank_state_e      state;
    bank_state_e      state_nxt;
    bank_state_e      eff;
    logic [RCD_W-1:0] rcd_cnt;
    logic [RAS_W-1:0] ras_cnt;
    logic [RP_W-1:0]  rp_cnt;
    logic             is_open;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BANK_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: commands act on the effective (timer-resolved) state
    always_comb begin
        state_nxt = eff;
        if (act) begin
            state_nxt = BANK_ACTIVATING;
        end else if (pre && is_open) begin
            state_nxt = BANK_PRECHARGING;
        end else if (rdwr && ap && (eff == BANK_ACTIVE)) begin
            state_nxt = BANK_PRECHARGING;
        end
    end

    // Outputs: a timer expiring on the sampling edge already counts as elapsed
    always_comb begin
        eff = state;
        if ((state == BANK_ACTIVATING) && (rcd_cnt == '0)) begin
            eff = BANK_ACTIVE;
        end
        if ((state == BANK_PRECHARGING) && (rp_cnt == '0)) begin
            eff = BANK_IDLE;
        end
        is_open     = (eff == BANK_ACTIVE) || (eff == BANK_ACTIVATING);
        eff_state_c = 2'(eff);
        ras_ok_c    = (ras_cnt == '0);
    end

    // Countdown timers and open-row capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcd_cnt  <= '0;
            ras_cnt  <= '0;
            rp_cnt   <= '0;
            open_row <= '0;
        end else begin
            if (act) begin
                rcd_cnt <= RCD_W'(TRCD - 1);
                ras_cnt <= RAS_W'(TRAS - 1);
            end else begin
                if (rcd_cnt != '0) rcd_cnt <= rcd_cnt - RCD_W'(1);
                if (ras_cnt != '0) ras_cnt <= ras_cnt - RAS_W'(1);
            end
            if ((state_nxt == BANK_PRECHARGING) && (eff != BANK_PRECHARGING)) begin
                rp_cnt <= pre ? RP_W'(TRP - 1) : RP_W'(TAP + TRP - 1);
            end else if (rp_cnt != '0) begin
                rp_cnt <= rp_cnt - RP_W'(1);
            end
            // ACT to an already open bank keeps the row that is really open
            if (act && !is_open) begin
                open_row <= row_in;
            end
        end
    end

endmodule

// File: rtl/ddr3_cmd_decoder.sv
// DDR3 command/address bus decoder: JEDEC command decode, per-bank timing
// legality, REF lockout, MR0 capture and registered command/error pulses.
module ddr3_cmd_decoder
    import ddr3_cmd_pkg::*;
#(
    parameter int unsigned BA_WIDTH   = 3,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned TRCD       = 6,
    parameter int unsigned TRP        = 6,
    parameter int unsigned TRAS       = 15,
    parameter int unsigned TRFC       = 64,
    parameter int unsigned TAP        = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cke,
    input  logic                  cs_n,
    input  logic                  ras_n,
    input  logic                  cas_n,
    input  logic                  we_n,
    input  logic [BA_WIDTH-1:0]   ba,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  cmd_valid,
    output logic [3:0]            cmd_type,
    output logic [BA_WIDTH-1:0]   cmd_bank,
    output logic [ADDR_WIDTH-1:0] cmd_row,
    output logic [9:0]            cmd_col,
    output logic                  cmd_ap,
    output logic                  cmd_bc4,
    output logic [1:0]            mr0_bl,
    output logic [3:0]            mr0_cl,
    output logic                  err_valid,
    output logic [3:0]            err_code
);

    localparam int unsigned NBANK = 1 << BA_WIDTH;
    localparam int unsigned RFC_W = $clog2(TRFC + 1);

    cmd_e                  cmd_c;
    err_e                  err_c;
    logic                  is_act;
    logic                  is_rdwr;
    logic                  is_pre;
    logic                  is_prea;
    logic [RFC_W-1:0]      rfc_cnt;
    logic [1:0]            bank_state [NBANK];
    logic [ADDR_WIDTH-1:0] open_row   [NBANK];
    logic [NBANK-1:0]      ras_ok;
    bank_state_e           sel_state;
    logic                  sel_open;
    logic                  any_busy;
    logic                  prea_viol;
    logic [ADDR_WIDTH-1:0] row_c;

    // Pin decode; nothing is decoded while deselected or clock-disabled
    always_comb begin
        cmd_c = CMD_NOP;
        if (cke && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  cmd_c = CMD_ACT;
                3'b101:  cmd_c = CMD_RD;
                3'b100:  cmd_c = CMD_WR;
                3'b010:  cmd_c = addr[10] ? CMD_PREA : CMD_PRE;
                3'b001:  cmd_c = CMD_REF;
                3'b000:  cmd_c = CMD_MRS;
                3'b110:  cmd_c = CMD_ZQ;
                default: cmd_c = CMD_NOP;
            endcase
        end
        is_act  = (cmd_c == CMD_ACT);
        is_rdwr = (cmd_c == CMD_RD) || (cmd_c == CMD_WR);
        is_pre  = (cmd_c == CMD_PRE);
        is_prea = (cmd_c == CMD_PREA);
    end

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic sel;
        assign sel = (ba == BA_WIDTH'(i));

        ddr3_bank_fsm #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .TRCD       (TRCD),
            .TRP        (TRP),
            .TRAS       (TRAS),
            .TAP        (TAP)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .act         (is_act && sel),
            .rdwr        (is_rdwr && sel),
            .ap          (addr[10]),
            .pre         ((is_pre && sel) || is_prea),
            .row_in      (addr),
            .eff_state_c (bank_state[i]),
            .ras_ok_c    (ras_ok[i]),
            .open_row    (open_row[i])
        );
    end

    // Whole-device views used by PREA, REF and MRS legality
    always_comb begin
        any_busy  = 1'b0;
        prea_viol = 1'b0;
        for (int i = 0; i < NBANK; i++) begin
            if (bank_state[i] != 2'(BANK_IDLE)) begin
                any_busy = 1'b1;
            end
            if (((bank_state[i] == 2'(BANK_ACTIVE)) || (bank_state[i] == 2'(BANK_ACTIVATING)))
                && !ras_ok[i]) begin
                prea_viol = 1'b1;
            end
        end
    end

    // Error classification in priority order, REF lockout first
    always_comb begin
        sel_state = bank_state_e'(bank_state[ba]);
        sel_open  = (sel_state == BANK_ACTIVE) || (sel_state == BANK_ACTIVATING);
        err_c     = ERR_NONE;
        if (cmd_c != CMD_NOP) begin
            if (rfc_cnt != '0) begin
                err_c = ERR_TRFC;
            end else begin
                case (cmd_c)
                    CMD_ACT: begin
                        if (sel_state == BANK_PRECHARGING) err_c = ERR_TRP;
                        else if (sel_state != BANK_IDLE)   err_c = ERR_ACT_OPEN;
                    end
                    CMD_RD, CMD_WR: begin
                        if (sel_state == BANK_ACTIVATING) err_c = ERR_TRCD;
                        else if (!sel_open)               err_c = ERR_NOT_OPEN;
                    end
                    CMD_PRE: begin
                        if (sel_open && !ras_ok[ba]) err_c = ERR_TRAS;
                    end
                    CMD_PREA: begin
                        if (prea_viol) err_c = ERR_TRAS;
                    end
                    CMD_REF, CMD_MRS: begin
                        if (any_busy) err_c = ERR_REF_OPEN;
                    end
                    default: err_c = ERR_NONE;
                endcase
            end
        end
        row_c = '0;
        if (is_act)       row_c = addr;
        else if (is_rdwr) row_c = open_row[ba];
    end

    // REF lockout countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rfc_cnt <= '0;
        end else if (cmd_c == CMD_REF) begin
            rfc_cnt <= RFC_W'(TRFC - 1);
        end else if (rfc_cnt != '0) begin
            rfc_cnt <= rfc_cnt - RFC_W'(1);
        end
    end

    // Registered command/error pulses and MR0 capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_type  <= '0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            cmd_ap    <= 1'b0;
            cmd_bc4   <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
            mr0_bl    <= '0;
            mr0_cl    <= '0;
        end else begin
            cmd_valid <= (cmd_c != CMD_NOP);
            cmd_type  <= 4'(cmd_c);
            cmd_bank  <= (cmd_c != CMD_NOP) ? ba : '0;
            cmd_row   <= row_c;
            cmd_col   <= is_rdwr ? addr[COL_W-1:0] : '0;
            cmd_ap    <= is_rdwr && addr[10];
            cmd_bc4   <= is_rdwr && (mr0_bl == MR0_BL_OTF) && !addr[12];
            err_valid <= (err_c != ERR_NONE);
            err_code  <= 4'(err_c);
            if ((cmd_c == CMD_MRS) && (ba == '0)) begin
                mr0_bl <= addr[1:0];
                mr0_cl <= {addr[6:4], addr[2]};
            end
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// Randomized + directed bench for ddr3_cmd_decoder with a timestamp-based
// reference model and a queue scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_ddr3_cmd_decoder;

    localparam int BA_WIDTH   = 3;
    localparam int ADDR_WIDTH = 14;
    localparam int TRCD = 6;
    localparam int TRP  = 6;
    localparam int TRAS = 15;
    localparam int TRFC = 64;
    localparam int TAP  = 10;
    localparam int NB   = 1 << BA_WIDTH;

    localparam int C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_PREA = 5;
    localparam int C_REF = 6, C_MRS = 7, C_ZQ = 8;
    localparam int S_IDLE = 0, S_OPENING = 1, S_OPEN = 2, S_CLOSING = 3;

    localparam logic [2:0] P_ACT = 3'b011, P_RD = 3'b101, P_WR = 3'b100, P_PRE = 3'b010;
    localparam logic [2:0] P_REF = 3'b001, P_MRS = 3'b000, P_ZQ = 3'b110, P_NOP = 3'b111;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  cke = 1'b0;
    logic                  cs_n = 1'b1;
    logic                  ras_n = 1'b1;
    logic                  cas_n = 1'b1;
    logic                  we_n = 1'b1;
    logic [BA_WIDTH-1:0]   ba = '0;
    logic [ADDR_WIDTH-1:0] addr = '0;
    logic                  cmd_valid;
    logic [3:0]            cmd_type;
    logic [BA_WIDTH-1:0]   cmd_bank;
    logic [ADDR_WIDTH-1:0] cmd_row;
    logic [9:0]            cmd_col;
    logic                  cmd_ap;
    logic                  cmd_bc4;
    logic [1:0]            mr0_bl;
    logic [3:0]            mr0_cl;
    logic                  err_valid;
    logic [3:0]            err_code;

    ddr3_cmd_decoder #(
        .BA_WIDTH(BA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TRCD(TRCD), .TRP(TRP),
        .TRAS(TRAS), .TRFC(TRFC), .TAP(TAP)
    ) dut (
        .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .addr(addr), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap),
        .cmd_bc4(cmd_bc4), .mr0_bl(mr0_bl), .mr0_cl(mr0_cl), .err_valid(err_valid),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_no; int ctype; int bank; int row; int col;
        int ap; int bc4; int ecode; int bl; int cl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    bit   mon_en = 1'b0;

    // Reference model: per-bank open flag plus timestamps of ACT and precharge completion
    bit m_open   [NB];
    int m_act_t  [NB];
    int m_idle_t [NB];
    int m_row    [NB];
    int m_lock_until;
    int m_bl;
    int m_cl;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 1'b0; m_act_t[i] = 0; m_idle_t[i] = 0; m_row[i] = 0;
        end
        m_lock_until = 0; m_bl = 0; m_cl = 0;
    endfunction

    function automatic int bank_status(int b, int t);
        if (m_open[b]) return ((t - m_act_t[b]) >= TRCD) ? S_OPEN : S_OPENING;
        return (t >= m_idle_t[b]) ? S_IDLE : S_CLOSING;
    endfunction

    function automatic void model_step(logic [2:0] rcw, int b, int a, int t);
        exp_t e;
        int   st;
        int   ec;
        bit   any;
        e = '{default: 0};
        case (rcw)
            P_ACT: e.ctype = C_ACT;
            P_RD:  e.ctype = C_RD;
            P_WR:  e.ctype = C_WR;
            P_PRE: e.ctype = (((a >> 10) & 1) != 0) ? C_PREA : C_PRE;
            P_REF: e.ctype = C_REF;
            P_MRS: e.ctype = C_MRS;
            P_ZQ:  e.ctype = C_ZQ;
            default: return;
        endcase
        e.edge_no = t;
        e.bank    = b;
        st = bank_status(b, t);
        ec = 0;
        case (e.ctype)
            C_ACT: begin
                if (st == S_CLOSING)   ec = 3;
                else if (st != S_IDLE) ec = 2;
                e.row = a;
                if (!m_open[b]) m_row[b] = a;
                m_open[b] = 1'b1; m_act_t[b] = t;
            end
            C_RD, C_WR: begin
                if (st == S_OPENING)                         ec = 4;
                else if (st == S_IDLE || st == S_CLOSING)    ec = 5;
                e.row = m_row[b];
                e.col = a & 32'h3ff;
                e.ap  = (a >> 10) & 1;
                e.bc4 = (m_bl == 1 && ((a >> 12) & 1) == 0) ? 1 : 0;
                if (e.ap == 1 && st == S_OPEN) begin
                    m_open[b] = 1'b0; m_idle_t[b] = t + TAP + TRP;
                end
            end
            C_PRE: begin
                if (m_open[b]) begin
                    if ((t - m_act_t[b]) < TRAS) ec = 6;
                    m_open[b] = 1'b0; m_idle_t[b] = t + TRP;
                end
            end
            C_PREA: begin
                for (int i = 0; i < NB; i++) begin
                    if (m_open[i]) begin
                        if ((t - m_act_t[i]) < TRAS) ec = 6;
                        m_open[i] = 1'b0; m_idle_t[i] = t + TRP;
                    end
                end
            end
            C_REF, C_MRS: begin
                any = 1'b0;
                for (int i = 0; i < NB; i++) if (bank_status(i, t) != S_IDLE) any = 1'b1;
                if (any) ec = 7;
            end
            default: ;
        endcase
        if (t < m_lock_until) ec = 1;
        if (e.ctype == C_REF) m_lock_until = t + TRFC;
        if (e.ctype == C_MRS && b == 0) begin
            m_bl = a & 3;
            m_cl = (((a >> 4) & 7) << 1) | ((a >> 2) & 1);
        end
        e.ecode = ec;
        e.bl    = m_bl;
        e.cl    = m_cl;
        q.push_back(e);
    endfunction

    task automatic drive(input logic k, input logic s, input logic [2:0] rcw, input int b, input int a);
        @(negedge clk);
        cke = k; cs_n = s; {ras_n, cas_n, we_n} = rcw;
        ba = BA_WIDTH'(b); addr = ADDR_WIDTH'(a);
        if (k && !s) model_step(rcw, b, a, edge_cnt + 1);
    endtask

    task automatic cmd(input logic [2:0] rcw, input int b, input int a);
        drive(1'b1, 1'b0, rcw, b, a);
    endtask

    // Idle cycles: explicit NOP, clock-disabled or deselected with random pins
    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            int         sel;
            logic [2:0] r;
            sel = $urandom_range(0, 2);
            r   = 3'($urandom);
            case (sel)
                0:       drive(1'b1, 1'b0, P_NOP, $urandom_range(0, NB-1), $urandom_range(0, 16383));
                1:       drive(1'b0, 1'($urandom_range(0, 1)), r, $urandom_range(0, NB-1), $urandom_range(0, 16383));
                default: drive(1'b1, 1'b1, r, $urandom_range(0, NB-1), $urandom_range(0, 16383));
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [47:0] got;
        got = {cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_ap, cmd_bc4,
               mr0_bl, mr0_cl, err_valid, err_code};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s outputs=%h expected all zero", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = P_NOP;
        #1;
        check_reset_outputs("reset_assert");
        model_reset();
        q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b0;
    endtask

    // Monitor: pops the expected item whenever a pulse is due and compares
    always @(posedge clk) begin
        exp_t e;
        bit   exp_pulse;
        #1;
        if (mon_en && !rst) begin
            exp_pulse = (q.size() > 0) && (q[0].edge_no == edge_cnt);
            checks++;
            if (cmd_valid !== exp_pulse) begin
                errors++;
                $display("FAIL pulse edge=%0d cmd_valid=%0b expected %0b", edge_cnt, cmd_valid, exp_pulse);
                if (exp_pulse) e = q.pop_front();
            end else if (exp_pulse) begin
                e = q.pop_front();
                checks++;
                if (cmd_type !== 4'(e.ctype) || cmd_bank !== 3'(e.bank) || cmd_row !== 14'(e.row) ||
                    cmd_col !== 10'(e.col) || cmd_ap !== 1'(e.ap) || cmd_bc4 !== 1'(e.bc4)) begin
                    errors++;
                    $display("FAIL cmd edge=%0d got type=%0d bank=%0d row=%h col=%h ap=%0b bc4=%0b expected type=%0d bank=%0d row=%h col=%h ap=%0d bc4=%0d",
                             edge_cnt, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_ap, cmd_bc4,
                             e.ctype, e.bank, e.row, e.col, e.ap, e.bc4);
                end
                checks++;
                if (err_valid !== (e.ecode != 0) || err_code !== 4'(e.ecode)) begin
                    errors++;
                    $display("FAIL err edge=%0d type=%0d got valid=%0b code=%0d expected code=%0d",
                             edge_cnt, e.ctype, err_valid, err_code, e.ecode);
                end
                checks++;
                if (mr0_bl !== 2'(e.bl) || mr0_cl !== 4'(e.cl)) begin
                    errors++;
                    $display("FAIL mr0 edge=%0d got bl=%b cl=%b expected bl=%0d cl=%0d",
                             edge_cnt, mr0_bl, mr0_cl, e.bl, e.cl);
                end
            end else begin
                checks++;
                if (err_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_err edge=%0d err_valid=%0b expected 0", edge_cnt, err_valid);
                end
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        mon_en = 1'b1;

        // MR0 capture
        cmd(P_MRS, 0, 32'h0A71);
        nop(2);

        // ACT then RD at exactly tRCD
        cmd(P_ACT, 2, 32'h1234); nop(5); cmd(P_RD, 2, 32'h0040);
        nop(3);

        // tRCD short by one, tRAS short by one, then tRAS exact
        cmd(P_ACT, 1, 32'h0321); nop(4); cmd(P_RD, 1, 32'h0008);
        nop(8); cmd(P_PRE, 1, 0);
        nop(10);
        cmd(P_ACT, 1, 32'h0777); nop(14); cmd(P_PRE, 1, 0);
        nop(8);

        // Auto-precharge: ACT one clock early gives tRP, exact is clean
        cmd(P_ACT, 0, 32'h0100); nop(5); cmd(P_RD, 0, 32'h0410);
        nop(14); cmd(P_ACT, 0, 32'h0200);
        nop(15); cmd(P_PRE, 0, 0); nop(8);
        cmd(P_ACT, 0, 32'h0300); nop(5); cmd(P_WR, 0, 32'h1420);
        nop(15); cmd(P_ACT, 0, 32'h0301);
        nop(15); cmd(P_PRE, 0, 0); nop(8);

        // REF with an active bank, then REF lockout boundary
        cmd(P_ACT, 3, 32'h0abc); nop(6); cmd(P_REF, 0, 0);
        nop(70); cmd(P_PRE, 0, 32'h0400); nop(10);
        cmd(P_REF, 0, 0); nop(62); cmd(P_ACT, 5, 32'h0055);
        nop(20); cmd(P_PRE, 0, 32'h0400); nop(10);
        cmd(P_REF, 0, 0); nop(63); cmd(P_ACT, 5, 32'h0056);
        nop(20); cmd(P_PRE, 0, 32'h0400); nop(8);

        // Reset mid-operation clears banks and MR0
        cmd(P_MRS, 0, 32'h1A75); cmd(P_ACT, 4, 32'h0444); nop(2);
        do_reset();
        cmd(P_RD, 4, 32'h0010);
        nop(3);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            int b;
            int a;
            r = $urandom_range(0, 99);
            b = $urandom_range(0, NB-1);
            a = $urandom_range(0, 16383);
            if (n == 1500)   do_reset();
            if (r < 45)      nop(1);
            else if (r < 62) cmd(P_ACT, b, a);
            else if (r < 72) cmd(P_RD, b, a);
            else if (r < 81) cmd(P_WR, b, a);
            else if (r < 91) cmd(P_PRE, b, a & ~32'h400);
            else if (r < 93) cmd(P_PRE, b, a | 32'h400);
            else if (r < 94) cmd(P_REF, b, a);
            else if (r < 97) cmd(P_MRS, (r == 96) ? 0 : b, a);
            else             cmd(P_ZQ, b, a);
        end
        nop(5);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
